// File: rtl/fb_pkg.sv
// Shared types and constants for the ping-pong frame buffer.
package fb_pkg;

    // Writer-side state: filling the back bank, or holding a finished frame until vsync.
    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_e;

    localparam int FB_DW_DEFAULT    = 8;
    localparam int FB_DEPTH_DEFAULT = 65536;

    // Index width needed to address 'depth' entries (at least one bit).
    function automatic int fb_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port block RAM, one write port, one registered read port.
// The read register resets to zero and holds its value while re_i is low.
module fb_bank
    import fb_pkg::*;
#(
    parameter int DW    = FB_DW_DEFAULT,
    parameter int DEPTH = FB_DEPTH_DEFAULT,
    parameter int IW    = fb_addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    (* ram_style = "block" *) logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port: callers only enable it for in-range addresses.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port with synchronous reset of the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame store: the writer fills the back bank while VGA scans the front bank.
// Banks swap only after frame_done and a vsync rising edge (or both in the same cycle).
// Optional macro FB_RD_OUTREG_EN adds an output register, making read latency 2.
// Handshake: a write is accepted on any cycle with wr_en=1 and wr_ready=1 and an
// in-range address; writes offered otherwise are dropped and set the sticky err flag.
// Reads have no back-pressure: every rd_en produces exactly one rd_valid pulse.
module frame_buffer_pingpong
    import fb_pkg::*;
#(
    parameter int DW    = FB_DW_DEFAULT,
    parameter int DEPTH = FB_DEPTH_DEFAULT,
    parameter int AW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          frame_done,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          vsync,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          front_sel,
    output logic          swap_pending,
    output logic          err
);

    localparam int            IW      = fb_addr_width(DEPTH);
    // One extra bit so DEPTH == 2**AW is still representable.
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

    fb_state_e     state_q, state_d;
    logic          front_q, front_d;
    logic          err_q, err_d;
    logic          vsync_q;
    logic          vs_rise;
    logic          wr_in_range, rd_in_range;
    logic          wr_commit;
    logic          rd_vld1_q, rd_sel_q, rd_oor_q;
    logic [DW-1:0] dout_a, dout_b, rd_mux;

    assign vs_rise     = vsync & ~vsync_q;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

    // Next-state logic: write acceptance, error capture and bank swap decisions.
    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        err_d     = err_q;
        wr_commit = 1'b0;
        case (state_q)
            FILL: begin
                if (wr_en) begin
                    if (wr_in_range) wr_commit = 1'b1;
                    else             err_d     = 1'b1;
                end
                if (frame_done) begin
                    if (vs_rise) front_d = ~front_q;
                    else         state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (wr_en) err_d = 1'b1;
                if (vs_rise) begin
                    front_d = ~front_q;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, bank select, sticky error and vsync edge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            front_q <= 1'b0;
            err_q   <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            err_q   <= err_d;
            vsync_q <= vsync;
        end
    end

    // Bank A is written when B is displayed and vice versa; reads go to the front bank.
    fb_bank #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_commit & front_q),
        .waddr_i (wr_addr[IW-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_en & rd_in_range & ~front_q),
        .raddr_i (rd_addr[IW-1:0]),
        .rdata_o (dout_a)
    );

    fb_bank #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_commit & ~front_q),
        .waddr_i (wr_addr[IW-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_en & rd_in_range & front_q),
        .raddr_i (rd_addr[IW-1:0]),
        .rdata_o (dout_b)
    );

    // Capture bank and range at issue so a swap on the same edge cannot redirect the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld1_q <= 1'b0;
            rd_sel_q  <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            rd_vld1_q <= rd_en;
            if (rd_en) begin
                rd_sel_q <= front_q;
                rd_oor_q <= ~rd_in_range;
            end
        end
    end

    assign rd_mux = rd_oor_q ? '0 : (rd_sel_q ? dout_b : dout_a);

`ifdef FB_RD_OUTREG_EN
    logic          rd_vld2_q;
    logic [DW-1:0] rd_data2_q;

    // Output pipeline stage after the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld2_q  <= 1'b0;
            rd_data2_q <= '0;
        end else begin
            rd_vld2_q <= rd_vld1_q;
            if (rd_vld1_q) rd_data2_q <= rd_mux;
        end
    end

    assign rd_valid = rd_vld2_q;
    assign rd_data  = rd_data2_q;
`else
    assign rd_valid = rd_vld1_q;
    assign rd_data  = rd_mux;
`endif

    assign front_sel    = front_q;
    assign err          = err_q;
    assign wr_ready     = (state_q == FILL);
    assign swap_pending = (state_q == WAIT_SWAP);

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for frame_buffer_pingpong (DEPTH=1000 build); read data checked by a scoreboard.
module tb_frame_buffer_pingpong;

    localparam int DW    = 8;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
`ifdef FB_RD_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          vsync;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          front_sel;
    logic          swap_pending;
    logic          err;

    logic [DW-1:0] exp_q[$];
    int            iss_q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic          vs_lvl;
    logic [DW-1:0] mon_exp;
    int            mon_iss;

    frame_buffer_pingpong #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .vsync        (vsync),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .front_sel    (front_sel),
        .swap_pending (swap_pending),
        .err          (err)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; reads push their expected data.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic fd, input logic re, input logic [AW-1:0] ra,
                         input logic [DW-1:0] rexp);
        @(negedge clk);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        frame_done = fd;
        vsync      = vs_lvl;
        rd_en      = re;
        rd_addr    = ra;
        if (re) begin
            exp_q.push_back(rexp);
            iss_q.push_back(cyc);
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cycle(1'b1, a, d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, a, e);
    endtask

    task automatic fdone();
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    // Monitor: pop and compare whenever the DUT presents read data.
    always @(posedge clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no read", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_iss = iss_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(mon_exp));
                check("rd_latency", 32'(cyc - mon_iss), 32'(LAT));
            end
        end
    end

    initial begin
        rst = 1'b1; vs_lvl = 1'b0;
        wr_en = 0; wr_addr = '0; wr_data = '0; frame_done = 0;
        rd_en = 0; rd_addr = '0; vsync = 0;
        repeat (3) idle();
        check("rst_front_sel", 32'(front_sel), 0);
        check("rst_swap_pending", 32'(swap_pending), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_err", 32'(err), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;

        // Fill bank B, then frame_done together with vsync rise: immediate swap.
        wr(5, 8'h11); wr(7, 8'h77);
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(16 + i));
        vs_lvl = 1'b1;
        fdone();
        idle();
        check("imm_front_sel", 32'(front_sel), 1);
        check("imm_swap_pending", 32'(swap_pending), 0);
        check("imm_wr_ready", 32'(wr_ready), 1);
        rd(7, 8'h77); rd(5, 8'h11);
        idle();

        // Fill bank A, frame_done with vsync steady high: wait for the swap.
        wr(5, 8'h22); wr(7, 8'h88); wr(9, 8'h5A);
        fdone();
        idle();
        check("wait_swap_pending", 32'(swap_pending), 1);
        check("wait_wr_ready", 32'(wr_ready), 0);
        check("wait_front_sel", 32'(front_sel), 1);
        check("wait_err_clear", 32'(err), 0);
        wr(9, 8'h99);
        idle();
        check("wait_write_err", 32'(err), 1);
        fdone();
        vs_lvl = 1'b0;
        idle();
        check("wait_fd_ignored", 32'(swap_pending), 1);
        check("wait_front_hold", 32'(front_sel), 1);

        // vsync rise with a read on the same cycle: read sees the pre-swap bank B.
        vs_lvl = 1'b1;
        rd(7, 8'h77);
        idle();
        check("swap_front_sel", 32'(front_sel), 0);
        check("swap_pending_clr", 32'(swap_pending), 0);
        check("swap_wr_ready", 32'(wr_ready), 1);
        rd(7, 8'h88); rd(9, 8'h5A); rd(5, 8'h22);
        idle(); idle();

        // Immediate swap to B, then a partial frame into A and reset mid-frame.
        vs_lvl = 1'b0;
        idle();
        vs_lvl = 1'b1;
        fdone();
        idle();
        check("imm2_front_sel", 32'(front_sel), 1);
        wr(5, 8'h33);
        idle(); idle(); idle();
        rst = 1'b1; vs_lvl = 1'b0; vsync = 1'b0;
        idle();
        check("midrst_front_sel", 32'(front_sel), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_rd_valid", 32'(rd_valid), 0);
        check("midrst_swap_pending", 32'(swap_pending), 0);
        rst = 1'b0;

        // Write 0xA5 to back bank B; front bank A still shows its own data.
        wr(5, 8'hA5);
        rd(5, 8'h33);
        idle(); idle();
        fdone();
        idle();
        check("b1_swap_pending", 32'(swap_pending), 1);
        check("b1_wr_ready", 32'(wr_ready), 0);
        vs_lvl = 1'b1;
        idle(); idle();
        check("b1_front_sel", 32'(front_sel), 1);
        check("b1_swap_done", 32'(swap_pending), 0);
        rd(5, 8'hA5);
        idle();

        // Range boundaries: last address accepted, DEPTH rejected; OOR reads return 0.
        wr(999, 8'h42);
        idle();
        check("inrange_err", 32'(err), 0);
        wr(1000, 8'h43);
        idle();
        check("oor_write_err", 32'(err), 1);
        rd(1000, 8'h00); rd(1023, 8'h00);

        // Back-to-back reads of bank B addresses 0..3, then hold.
        rd(0, 8'h10); rd(1, 8'h11); rd(2, 8'h12); rd(3, 8'h13);
        repeat (4) idle();
        check("hold_rd_valid", 32'(rd_valid), 0);
        check("hold_rd_data", 32'(rd_data), 32'h13);
        check("err_sticky", 32'(err), 1);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) idle();
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
